even_parity_rx: RTL and testbench



---
 rtl/even_parity_pkg.sv | 15 +
 rtl/parity_acc.sv | 19 +
 rtl/even_parity_rx.sv | 106 ++++++++++
 tb/tb_even_parity_rx.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/even_parity_pkg.sv
// Shared types and constants for the even-parity serial receiver.
package even_parity_pkg;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   // Counter must be able to hold DATA_W itself, not just DATA_W-1.
   function automatic int bit_cnt_width(input int data_w);
      return $clog2(data_w + 1);
   endfunction

endpackage

// File: rtl/parity_acc.sv
// 1-bit XOR accumulator with synchronous clear and enable.
module parity_acc (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic din,
   output logic acc
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc <= 1'b0;
      end else if (en) begin
         acc <= acc ^ din;
      end
   end

endmodule

// File: rtl/even_parity_rx.sv
// Serial frame receiver with even-parity and stop-bit checking.
// Optional saturating parity-error counter enabled by EVEN_PARITY_ERR_CNT_EN.
module even_parity_rx
   import even_parity_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic              rx_bit,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy,
   output logic [CNT_W-1:0]  err_cnt
);

   localparam int CW = bit_cnt_width(DATA_W);

   state_t            state_reg;
   logic [CW-1:0]     cnt_reg;
   logic [DATA_W-1:0] shift_reg;
   logic              perr_n_reg;
   logic              acc;
   logic              acc_clr;
   logic              acc_en;

   assign acc_clr = rx_valid && (state_reg == IDLE) && (rx_bit == START_BIT);
   assign acc_en  = rx_valid && (state_reg == DATA);
   assign busy    = (state_reg != IDLE);

   parity_acc u_parity_acc (
      .clk (clk),
      .rst (rst),
      .clr (acc_clr),
      .en  (acc_en),
      .din (rx_bit),
      .acc (acc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         shift_reg  <= '0;
         perr_n_reg <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         if (rx_valid) begin
            case (state_reg)
               IDLE: begin
                  if (rx_bit == START_BIT) begin
                     cnt_reg   <= '0;
                     state_reg <= DATA;
                  end
               end
               DATA: begin
                  for (int i = 0; i < DATA_W; i++) begin
                     if (cnt_reg == CW'(i)) shift_reg[i] <= rx_bit;
                  end
                  cnt_reg <= cnt_reg + CW'(1);
                  if (cnt_reg == CW'(DATA_W - 1)) state_reg <= PARITY;
               end
               PARITY: begin
                  perr_n_reg <= acc ^ rx_bit;
                  state_reg  <= STOP;
               end
               STOP: begin
                  // Outputs change only here so they stay stable between frames.
                  data_out   <= shift_reg;
                  parity_err <= perr_n_reg;
                  frame_err  <= (rx_bit != STOP_BIT);
                  data_valid <= 1'b1;
                  state_reg  <= IDLE;
               end
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

`ifdef EVEN_PARITY_ERR_CNT_EN
   logic [CNT_W-1:0] err_cnt_reg;

   // Counted on the stop edge so err_cnt moves together with data_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_reg <= '0;
      end else if (rx_valid && (state_reg == STOP) && perr_n_reg && (err_cnt_reg != '1)) begin
         err_cnt_reg <= err_cnt_reg + CNT_W'(1);
      end
   end

   assign err_cnt = err_cnt_reg;
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_even_parity_rx.sv
// Directed, table-driven bench for even_parity_rx (DATA_W=8, CNT_W=8).
module tb_even_parity_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_valid = 1'b0;
   logic       rx_bit = 1'b1;
   logic [7:0] data_out;
   logic       data_valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;
   logic [7:0] err_cnt;

`ifdef EVEN_PARITY_ERR_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   int tests = 0;
   int fails = 0;
   int dv_count = 0;
   int busy_cycles = 0;

   even_parity_rx #(.DATA_W(8), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_valid   (rx_valid),
      .rx_bit     (rx_bit),
      .data_out   (data_out),
      .data_valid (data_valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .busy       (busy),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (data_valid) dv_count++;
      if (busy) busy_cycles++;
   end

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop;
      int         pre_idle;
      int         max_gap;
      logic       exp_perr;
      logic       exp_ferr;
      int         exp_cnt;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b, input int gap);
      for (int k = 0; k < gap; k++) begin
         rx_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      rx_valid = 1'b1;
      rx_bit   = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_bit   = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                             input int pre_idle, input int max_gap);
      for (int k = 0; k < pre_idle; k++) send_bit(1'b1, 0);
      send_bit(1'b0, int'($urandom_range(max_gap)));
      for (int k = 0; k < 8; k++) send_bit(d[k], int'($urandom_range(max_gap)));
      send_bit(par, int'($urandom_range(max_gap)));
      send_bit(stop, int'($urandom_range(max_gap)));
   endtask

   initial begin
      int dv_before;
      int exp_cnt;

      //          data   par   stop  pre gap perr  ferr  cnt
      vecs[0] = '{8'hA5, 1'b0, 1'b1, 0,  0,  1'b0, 1'b0, 0};
      vecs[1] = '{8'h07, 1'b0, 1'b1, 0,  0,  1'b1, 1'b0, 1};
      vecs[2] = '{8'h3C, 1'b0, 1'b0, 0,  0,  1'b0, 1'b1, 1};
      vecs[3] = '{8'h81, 1'b0, 1'b1, 3,  3,  1'b0, 1'b0, 1};
      vecs[4] = '{8'h00, 1'b1, 1'b1, 0,  1,  1'b1, 1'b0, 2};
      vecs[5] = '{8'h7F, 1'b0, 1'b0, 2,  2,  1'b1, 1'b1, 3};

      repeat (3) @(posedge clk);
      #1;
      check("rst_data_out", 32'(data_out), 0);
      check("rst_data_valid", 32'(data_valid), 0);
      check("rst_parity_err", 32'(parity_err), 0);
      check("rst_frame_err", 32'(frame_err), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_err_cnt", 32'(err_cnt), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 6; i++) begin
         busy_cycles = 0;
         dv_before   = dv_count;
         send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, vecs[i].pre_idle, vecs[i].max_gap);
         exp_cnt = CNT_EN ? vecs[i].exp_cnt : 0;
         check($sformatf("v%0d_data_valid", i), 32'(data_valid), 1);
         check($sformatf("v%0d_data_out", i), 32'(data_out), 32'(vecs[i].data));
         check($sformatf("v%0d_parity_err", i), 32'(parity_err), 32'(vecs[i].exp_perr));
         check($sformatf("v%0d_frame_err", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
         check($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'(exp_cnt));
         if (i == 0) check("v0_busy_cycles", 32'(busy_cycles), 10);
         @(posedge clk);
         #1;
         check($sformatf("v%0d_pulse_count", i), 32'(dv_count - dv_before), 1);
         check($sformatf("v%0d_data_valid_low", i), 32'(data_valid), 0);
         check($sformatf("v%0d_data_out_hold", i), 32'(data_out), 32'(vecs[i].data));
         $display("[TB] frame %0d data=%02h par=%0b stop=%0b -> out=%02h perr=%0b ferr=%0b cnt=%0d",
                  i, vecs[i].data, vecs[i].par, vecs[i].stop, data_out, parity_err, frame_err, err_cnt);
      end

      // Abort a frame of 0xFF after four data bits.
      dv_before = dv_count;
      send_bit(1'b0, 0);
      for (int k = 0; k < 4; k++) send_bit(1'b1, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_busy", 32'(busy), 0);
      check("abort_data_out", 32'(data_out), 0);
      check("abort_err_cnt", 32'(err_cnt), 0);
      send_frame(8'h12, 1'b0, 1'b1, 0, 0);
      check("after_abort_data_valid", 32'(data_valid), 1);
      check("after_abort_data_out", 32'(data_out), 32'h12);
      check("after_abort_parity_err", 32'(parity_err), 0);
      check("after_abort_frame_err", 32'(frame_err), 0);
      check("after_abort_pulses", 32'(dv_count - dv_before), 0);
      @(posedge clk);
      #1;
      check("after_abort_total_pulses", 32'(dv_count - dv_before), 1);
      $display("[TB] abort then frame 12 -> out=%02h perr=%0b ferr=%0b", data_out, parity_err, frame_err);

      // Back-to-back bad-parity frames: start bit lands on the data_valid cycle.
      dv_before = dv_count;
      for (int n = 0; n < 300; n++) begin
         send_frame(8'h01, 1'b0, 1'b1, 0, 0);
         exp_cnt = CNT_EN ? ((n + 1 > 255) ? 255 : n + 1) : 0;
         check($sformatf("sat%0d_err_cnt", n), 32'(err_cnt), 32'(exp_cnt));
      end
      check("sat_parity_err", 32'(parity_err), 1);
      check("sat_data_out", 32'(data_out), 32'h01);
      repeat (5) @(posedge clk);
      #1;
      check("sat_pulses", 32'(dv_count - dv_before), 300);
      check("sat_hold", 32'(err_cnt), CNT_EN ? 32'd255 : 32'd0);
      $display("[TB] 300 bad-parity frames -> err_cnt=%0d", err_cnt);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
